// File: rtl/priority_encoder_rr_if.sv
// Request/result bundle for priority_encoder_rr: request side inputs and the
// registered index/handshake outputs. The slave modport is the encoder's view.
interface priority_encoder_rr_if #(
    parameter int N = 8,
    parameter int W = $clog2(N)
);
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic         out_multi;
    logic [N-1:0] grant;
    logic         zero;

    modport master (
        output req, mode, out_ready,
        input  out_valid, out_idx, out_multi, grant, zero
    );

    modport slave (
        input  req, mode, out_ready,
        output out_valid, out_idx, out_multi, grant, zero
    );
endinterface

// File: rtl/priority_encoder_rr.sv
// Registered N-to-log2(N) request encoder with fixed or round-robin priority
// and a single-entry valid/ready output register.
module priority_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    priority_encoder_rr_if.slave        bus
);

    logic         valid_q, valid_d;
    logic [W-1:0] idx_q,   idx_d;
    logic         multi_q, multi_d;
    logic [N-1:0] grant_q, grant_d;
    logic         zero_q,  zero_d;
    logic [W-1:0] ptr_q,   ptr_d;

    logic         load_s;
    logic [W-1:0] sel_s;

    // Lowest-index set bit; iterating downwards lets the last hit win.
    function automatic logic [W-1:0] fixed_select(input logic [N-1:0] r);
        logic [W-1:0] s;
        s = {W{1'b0}};
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i[W-1:0]]) begin
                s = i[W-1:0];
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    // First set bit scanning from p upwards with wrap-around.
    function automatic logic [W-1:0] rr_select(input logic [N-1:0] r, input logic [W-1:0] p);
        logic [W-1:0] s;
        int           j;
        s = {W{1'b0}};
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(p) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            if (r[j[W-1:0]]) begin
                s = j[W-1:0];
            end else begin
                s = s;
            end
        end
        return s;
    endfunction

    function automatic logic more_than_one(input logic [N-1:0] r);
        return (r & (r - N'(1))) != {N{1'b0}};
    endfunction

    assign load_s = (!valid_q || bus.out_ready) && (bus.req != {N{1'b0}});
    assign sel_s  = bus.mode ? rr_select(bus.req, ptr_q) : fixed_select(bus.req);

    // Next-state: load, drain-on-accept, or hold.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        multi_d = multi_q;
        grant_d = {N{1'b0}};
        ptr_d   = ptr_q;
        zero_d  = (bus.req == {N{1'b0}});
        if (load_s) begin
            valid_d = 1'b1;
            idx_d   = sel_s;
            multi_d = more_than_one(bus.req);
            grant_d = N'(1) << sel_s;
            ptr_d   = (sel_s == W'(N - 1)) ? {W{1'b0}} : sel_s + W'(1);
        end else if (valid_q && bus.out_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= {W{1'b0}};
            multi_q <= 1'b0;
            grant_q <= {N{1'b0}};
            zero_q  <= 1'b1;
            ptr_q   <= {W{1'b0}};
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
            multi_q <= multi_d;
            grant_q <= grant_d;
            zero_q  <= zero_d;
            ptr_q   <= ptr_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_multi = multi_q;
    assign bus.grant     = grant_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed and random stimulus for priority_encoder_rr (N=8) checked against a
// behavioural model built from set-index lists and a next-pointer integer.
module tb_priority_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic rst_n;

    priority_encoder_rr_if #(.N(N)) bus_if ();

    priority_encoder_rr #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state.
    logic         m_valid;
    int           m_idx;
    logic         m_multi;
    logic [N-1:0] m_grant;
    logic         m_zero;
    int           m_ptr;

    task automatic model_reset();
        m_valid = 1'b0; m_idx = 0; m_multi = 1'b0;
        m_grant = '0;   m_zero = 1'b1; m_ptr = 0;
    endtask

    task automatic model_update(input logic [N-1:0] r, input logic m, input logic rdy);
        int set_bits[$];
        int pick;
        for (int i = 0; i < N; i++) if (r[i]) set_bits.push_back(i);
        m_grant = '0;
        if ((!m_valid || rdy) && set_bits.size() > 0) begin
            pick = set_bits[0];
            if (m) begin
                foreach (set_bits[k]) begin
                    if (set_bits[k] >= m_ptr) begin
                        pick = set_bits[k];
                        break;
                    end
                end
            end
            m_valid = 1'b1;
            m_idx   = pick;
            m_multi = ($countones(r) > 1);
            m_grant[pick] = 1'b1;
            m_ptr   = (pick + 1) % N;
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        m_zero = (r == '0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"}, 32'(bus_if.out_valid), 32'(m_valid));
        check({tag, ".idx"},   32'(bus_if.out_idx),   32'(m_idx));
        check({tag, ".multi"}, 32'(bus_if.out_multi), 32'(m_multi));
        check({tag, ".grant"}, 32'(bus_if.grant),     32'(m_grant));
        check({tag, ".zero"},  32'(bus_if.zero),      32'(m_zero));
    endtask

    task automatic step(input string tag, input logic [N-1:0] r, input logic m, input logic rdy);
        bus_if.req = r; bus_if.mode = m; bus_if.out_ready = rdy;
        @(posedge clk);
        model_update(r, m, rdy);
        #1;
        check_all(tag);
    endtask

    int rr_expect[5] = '{0, 2, 7, 0, 2};
    logic [N-1:0] rnd_req;

    initial begin
        rst_n = 1'b0;
        bus_if.req = 8'hFF; bus_if.mode = 1'b1; bus_if.out_ready = 1'b1;
        model_reset();
        #12;
        check_all("reset");
        check("reset.grant_const", 32'(bus_if.grant), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step("first_load", 8'hFF, 1'b1, 1'b1);
        check("first_load.grant_const", 32'(bus_if.grant), 32'h01);

        for (int c = 0; c < 3; c++) begin
            step("fixed", 8'b1010_0100, 1'b0, 1'b1);
            check("fixed.idx_const", 32'(bus_if.out_idx), 32'd2);
        end

        step("rr_prime", 8'h80, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            step("rr_wrap", 8'b1000_0101, 1'b1, 1'b1);
            check("rr_wrap.idx_const", 32'(bus_if.out_idx), 32'(rr_expect[c]));
        end

        step("bp_load", 8'h10, 1'b0, 1'b1);
        for (int c = 0; c < 4; c++) begin
            step("bp_hold", 8'h02, 1'b0, 1'b0);
            check("bp_hold.idx_const", 32'(bus_if.out_idx), 32'd4);
        end
        step("bp_release", 8'h02, 1'b0, 1'b1);
        check("bp_release.grant_const", 32'(bus_if.grant), 32'h02);

        step("drain", 8'h00, 1'b0, 1'b1);
        check("drain.valid_const", 32'(bus_if.out_valid), 32'd0);
        step("zero_clear", 8'h08, 1'b0, 1'b1);
        check("zero_clear.idx_const", 32'(bus_if.out_idx), 32'd3);

        for (int c = 0; c < 400; c++) begin
            rnd_req = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
            step("random", rnd_req, 1'($urandom), ($urandom_range(0, 9) < 7));
        end

        for (int c = 0; c < 2; c++) step("rr_run", 8'b1010_0100, 1'b1, 1'b1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        #2;
        rst_n = 1'b1;
        step("restart", 8'b1010_0100, 1'b1, 1'b1);
        check("restart.idx_const", 32'(bus_if.out_idx), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
